// File: rtl/seg7_scan_decoder.sv
// Recovers BCD digits from a multiplexed 7-segment bus. Each digit pattern must
// dwell stably before it is accepted; complete frames are offered on valid/ready.
module seg7_scan_decoder #(
  parameter int DIGITS     = 4,
  parameter int STABLE_CYC = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [6:0]            SEG,
  input  logic [DIGITS-1:0]     DIG_SEL,
  output logic [4*DIGITS-1:0]   OUT_BCD,
  output logic                  OUT_ERR,
  output logic                  OUT_VALID,
  input  logic                  OUT_READY,
  output logic                  OVERRUN
);

  typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_HELD} state_e;

  state_e                state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [6:0]            s_seg_q;
  logic [DIGITS-1:0]     s_sel_q;
  logic [4*DIGITS-1:0]   w_q, w_d;
  logic [DIGITS-1:0]     seen_q, seen_d;
  logic                  err_acc_q, err_acc_d;
  logic [4*DIGITS-1:0]   out_bcd_q, out_bcd_d;
  logic                  out_err_q, out_err_d;
  logic                  out_valid_q, out_valid_d;
  logic                  overrun_q, overrun_d;

  logic                  in_diff;
  logic                  in_onehot;
  logic                  accept;
  logic                  cur_err;
  logic [3:0]            cur_nib;
  logic [4*DIGITS-1:0]   w_new;
  logic [DIGITS-1:0]     seen_new;

  // Returns {error, nibble}; blank decodes to F, anything non-canonical to E.
  function automatic logic [4:0] decode(input logic [6:0] seg);
    case (seg)
      7'h7E:   decode = 5'h00;
      7'h30:   decode = 5'h01;
      7'h6D:   decode = 5'h02;
      7'h79:   decode = 5'h03;
      7'h33:   decode = 5'h04;
      7'h5B:   decode = 5'h05;
      7'h5F:   decode = 5'h06;
      7'h70:   decode = 5'h07;
      7'h7F:   decode = 5'h08;
      7'h7B:   decode = 5'h09;
      7'h00:   decode = 5'h0F;
      default: decode = 5'h1E;
    endcase
  endfunction

  assign in_diff   = (SEG != s_seg_q) || (DIG_SEL != s_sel_q);
  assign in_onehot = (DIG_SEL != '0) && ((DIG_SEL & (DIG_SEL - DIGITS'(1))) == '0);
  assign accept    = (state_q == ST_SETTLE) && (cnt_q == 8'(STABLE_CYC - 1));

  // NOTE: RST is sampled on the clock edge, so it sits inside the clocked branch;
  // W is reset too, since a partial frame must never leak into the next one.
  // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      s_seg_q     <= '0;
      s_sel_q     <= '0;
      w_q         <= '0;
      seen_q      <= '0;
      err_acc_q   <= 1'b0;
      out_bcd_q   <= '0;
      out_err_q   <= 1'b0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      s_seg_q     <= SEG;
      s_sel_q     <= DIG_SEL;
      w_q         <= w_d;
      seen_q      <= seen_d;
      err_acc_q   <= err_acc_d;
      out_bcd_q   <= out_bcd_d;
      out_err_q   <= out_err_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  // Stability FSM: any change restarts the dwell; a full dwell is accepted once.
  // NOTE: each comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (in_diff) begin
      cnt_d   = '0;
      state_d = in_onehot ? ST_SETTLE : ST_IDLE;
    end else if (state_q == ST_SETTLE) begin
      cnt_d   = cnt_q + 8'd1;
      state_d = accept ? ST_HELD : ST_SETTLE;
    end
  end

  always_comb begin
    {cur_err, cur_nib} = decode(s_seg_q);
    w_new    = w_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (s_sel_q[i]) w_new[4*i +: 4] = cur_nib;
    end
    seen_new = seen_q | s_sel_q;

    w_d         = w_q;
    seen_d      = seen_q;
    err_acc_d   = err_acc_q;
    out_bcd_d   = out_bcd_q;
    out_err_d   = out_err_q;
    out_valid_d = out_valid_q && !OUT_READY;
    overrun_d   = 1'b0;

    if (accept) begin
      w_d = w_new;
      if (&seen_new) begin
        // A frame still waiting for a consumer is replaced, flagged as overrun.
        out_bcd_d   = w_new;
        out_err_d   = err_acc_q | cur_err;
        out_valid_d = 1'b1;
        overrun_d   = out_valid_q && !OUT_READY;
        seen_d      = '0;
        err_acc_d   = 1'b0;
      end else begin
        seen_d    = seen_new;
        err_acc_d = err_acc_q | cur_err;
      end
    end
  end

  assign OUT_BCD   = out_bcd_q;
  assign OUT_ERR   = out_err_q;
  assign OUT_VALID = out_valid_q;
  assign OVERRUN   = overrun_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Randomised scoreboard bench for seg7_scan_decoder: a run-length model of the
// input stream predicts frames, a monitor compares every handshake transfer.
module tb_seg7_scan_decoder;

  localparam int DIGITS     = 4;
  localparam int STABLE_CYC = 4;

  typedef struct {
    logic [15:0] bcd;
    logic        err;
  } frame_t;

  logic        CLK;
  logic        RST;
  logic [6:0]  SEG;
  logic [3:0]  DIG_SEL;
  logic [15:0] OUT_BCD;
  logic        OUT_ERR;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic        OVERRUN;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_ovr  = 0;
  int ovr_seen = 0;

  frame_t exp_q[$];

  // Reference model state: the current run of identical inputs plus frame assembly.
  logic [6:0]  run_seg;
  logic [3:0]  run_sel;
  int          run_len;
  logic [3:0]  m_seen;
  logic [15:0] m_w;
  logic        m_err;

  logic [6:0] digit_pat [10] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33,
                                 7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B};

  seg7_scan_decoder #(.DIGITS(DIGITS), .STABLE_CYC(STABLE_CYC)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .SEG      (SEG),
    .DIG_SEL  (DIG_SEL),
    .OUT_BCD  (OUT_BCD),
    .OUT_ERR  (OUT_ERR),
    .OUT_VALID(OUT_VALID),
    .OUT_READY(OUT_READY),
    .OVERRUN  (OVERRUN)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    run_seg = '0;
    run_sel = '0;
    run_len = 0;
    m_seen  = '0;
    m_w     = '0;
    m_err   = 1'b0;
    exp_q.delete();
  endtask

  task automatic model_accept(input logic [6:0] seg, input logic [3:0] sel);
    int     idx;
    logic   bad;
    logic [3:0] nib;
    frame_t f;
    idx = 0;
    for (int i = 0; i < DIGITS; i++) if (sel[i]) idx = i;
    nib = 4'hE;
    bad = 1'b1;
    if (seg == 7'h00) begin
      nib = 4'hF;
      bad = 1'b0;
    end
    for (int v = 0; v < 10; v++) begin
      if (digit_pat[v] == seg) begin
        nib = 4'(v);
        bad = 1'b0;
      end
    end
    m_w[4*idx +: 4] = nib;
    m_seen[idx]     = 1'b1;
    m_err           = m_err | bad;
    if (m_seen == 4'hF) begin
      f.bcd = m_w;
      f.err = m_err;
      if (!OUT_READY && exp_q.size() > 0) begin
        exp_q[exp_q.size()-1] = f;
        exp_ovr++;
      end else begin
        exp_q.push_back(f);
      end
      m_seen = '0;
      m_err  = 1'b0;
    end
  endtask

  // One input cycle: extend or restart the run; a one-hot run is accepted when
  // it first reaches STABLE_CYC cycles.
  task automatic model_step(input logic [6:0] seg, input logic [3:0] sel);
    if (seg == run_seg && sel == run_sel) run_len++;
    else begin
      run_seg = seg;
      run_sel = sel;
      run_len = 1;
    end
    if (run_len == STABLE_CYC && $countones(sel) == 1) model_accept(seg, sel);
  endtask

  task automatic drive(input logic [6:0] seg, input logic [3:0] sel, input int n);
    for (int k = 0; k < n; k++) begin
      SEG     = seg;
      DIG_SEL = sel;
      model_step(seg, sel);
      @(negedge CLK);
    end
  endtask

  task automatic send_frame(input logic [6:0] p0, input logic [6:0] p1,
                            input logic [6:0] p2, input logic [6:0] p3, input int dwell);
    drive(p0, 4'b0001, dwell);
    drive(p1, 4'b0010, dwell);
    drive(p2, 4'b0100, dwell);
    drive(p3, 4'b1000, dwell);
    drive(7'h00, 4'b0000, 3);
  endtask

  task automatic do_reset();
    RST     = 1'b1;
    SEG     = '0;
    DIG_SEL = '0;
    model_reset();
    repeat (2) @(negedge CLK);
    RST = 1'b0;
  endtask

  function automatic logic [6:0] rand_pat();
    int r;
    r = int'($urandom_range(0, 9));
    if (r < 7) return digit_pat[$urandom_range(0, 9)];
    if (r == 7) return 7'h00;
    return 7'($urandom_range(0, 127));
  endfunction

  // Monitor: sample mid-cycle, pop an expected frame on every transfer.
  initial begin
    frame_t f;
    forever begin
      @(negedge CLK);
      #1;
      if (!RST) begin
        if (OUT_VALID && OUT_READY) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL spurious_frame: got bcd %0h err %0b, expected no frame", OUT_BCD, OUT_ERR);
          end else begin
            f = exp_q.pop_front();
            check("frame_bcd", 32'(OUT_BCD), 32'(f.bcd));
            check("frame_err", 32'(OUT_ERR), 32'(f.err));
          end
        end
        if (OVERRUN) ovr_seen++;
      end
    end
  end

  initial begin
    int lat;
    bit got;
    OUT_READY = 1'b1;
    RST       = 1'b1;
    SEG       = '0;
    DIG_SEL   = '0;
    @(negedge CLK);
    do_reset();
    #1;
    check("rst_bcd", 32'(OUT_BCD), 32'h0);
    check("rst_err", 32'(OUT_ERR), 32'h0);
    check("rst_valid", 32'(OUT_VALID), 32'h0);
    check("rst_overrun", 32'(OVERRUN), 32'h0);
    @(negedge CLK);

    // Basic frame 4321 with free-running consumer.
    send_frame(7'h30, 7'h6D, 7'h79, 7'h33, 6);
    check("idle_valid_low", 32'(OUT_VALID), 32'h0);

    // Invalid pattern on digit 2, then a clean frame.
    send_frame(7'h7E, 7'h7E, 7'h7C, 7'h7E, 6);
    send_frame(7'h7E, 7'h30, 7'h6D, 7'h79, 6);

    // Short dwell on digit 1 is ignored; latency of the final digit is measured.
    drive(7'h30, 4'b0010, 3);
    drive(7'h5B, 4'b0001, 6);
    drive(7'h30, 4'b0010, 6);
    drive(7'h7F, 4'b0100, 6);
    lat = 0;
    got = 1'b0;
    fork
      drive(7'h33, 4'b1000, 6);
      begin
        for (int k = 0; k < 20 && !got; k++) begin
          @(posedge CLK);
          #1;
          lat++;
          if (OUT_VALID) got = 1'b1;
        end
      end
    join
    check("accept_latency", 32'(lat), 32'(STABLE_CYC + 1));
    drive(7'h00, 4'b0000, 3);

    // Non-one-hot select must not disturb the partially assembled frame.
    drive(7'h7E, 4'b0001, 6);
    drive(7'h30, 4'b0010, 6);
    drive(7'h7F, 4'b0011, 10);
    drive(7'h6D, 4'b0100, 6);
    drive(7'h79, 4'b1000, 6);
    drive(7'h00, 4'b0000, 3);

    // Stalled consumer across two frames: second overwrites first.
    OUT_READY = 1'b0;
    send_frame(7'h30, 7'h6D, 7'h79, 7'h33, 6);
    send_frame(7'h5B, 7'h5F, 7'h70, 7'h7F, 6);
    check("stall_valid_high", 32'(OUT_VALID), 32'h1);
    check("stall_bcd", 32'(OUT_BCD), 32'h8765);
    OUT_READY = 1'b1;
    drive(7'h00, 4'b0000, 3);
    check("after_drain_valid", 32'(OUT_VALID), 32'h0);

    // Reset mid-frame discards digits 0 and 1.
    drive(7'h7B, 4'b0001, 6);
    drive(7'h7B, 4'b0010, 6);
    do_reset();
    @(negedge CLK);
    send_frame(7'h7B, 7'h7B, 7'h7B, 7'h7B, 6);

    // Randomised frames with short glitches on arbitrary digits.
    for (int fr = 0; fr < 20; fr++) begin
      for (int d = 0; d < DIGITS; d++) begin
        if ($urandom_range(0, 2) == 0)
          drive(rand_pat(), 4'(1 << $urandom_range(0, 3)), int'($urandom_range(1, 3)));
        drive(rand_pat(), 4'(1 << d), int'($urandom_range(4, 8)));
      end
      drive(7'h00, 4'b0000, 3);
    end

    drive(7'h00, 4'b0000, 5);
    check("frames_outstanding", 32'(exp_q.size()), 32'h0);
    check("overrun_count", 32'(ovr_seen), 32'(exp_ovr));
    check("final_valid", 32'(OUT_VALID), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seg7_scan_decoder.md
# seg7_scan_decoder

- Receive-side counterpart of the BCD-to-7-segment decoder.
- Samples a multiplexed 7-segment bus (segment lines plus one-hot digit strobe) and recovers one BCD nibble per digit position.
- Qualifies each pattern through a stability filter.
- Assembles a complete frame of digits and presents it on a valid/ready handshake.
- Sits between the display-drive pins (or a display-bus tap) and any consumer that needs the shown value numerically: self-check logic, a loopback monitor or a UART reporter.

## Interface
- DIGITS, 4, number of multiplexed digit positions (1-8)
- STABLE_CYC, 4, consecutive identical registered samples required to accept a digit (1-255)
- CLK  in  1  system clock; all logic on rising edge
- RST  in  1  synchronous, active-high reset
- SEG  in  7  segment pattern, active-high, SEG[6:0] = {a,b,c,d,e,f,g}
- DIG_SEL  in  DIGITS  digit strobe, active-high, bit i selects digit i
- OUT_BCD  out  4*DIGITS  captured frame, digit i at [4i+3:4i]
- OUT_ERR  out  1  frame contains at least one invalid pattern
- OUT_VALID  out  1  frame available
- OUT_READY  in  1  consumer accepts frame
- OVERRUN  out  1  one-cycle pulse: unconsumed frame overwritten

## Operation
- Input stage: SEG and DIG_SEL are registered once into sample register S before any use. The register is reset to all zeros.
- Stability FSM states:
  - IDLE: S has zero or more-than-one DIG_SEL bits set.
  - SETTLE: counting.
  - HELD: the current dwell has been accepted.
- Counter cnt (8 bit) and FSM update on every edge, based on the incoming input versus S:
  - Input differs from S: cnt<=0, next state is SETTLE if the incoming select is one-hot, else IDLE.
  - Input equals S and state is SETTLE: cnt increments.
  - Input equals S and state is HELD or IDLE: hold.
- Accept: in the cycle where state is SETTLE and cnt==STABLE_CYC-1. On the next edge the state becomes HELD, so each dwell is accepted exactly once.
- Decode table, canonical patterns only:
  - 0=7E, 1=30, 2=6D, 3=79, 4=33, 5=5B, 6=5F, 7=70, 8=7F, 9=7B
  - Blank 00 gives nibble F and is valid.
  - Any other pattern gives nibble E and sets the frame error flag.
- On accept of digit i:
  - Store the nibble in working register W[i] and set seen[i].
  - An invalid pattern also sets err_acc.
  - Re-accepting an already-seen digit overwrites W[i], and seen[i] stays set.
- Frame completion: the accept makes seen all-ones, counting the digit being written. On that same edge:
  - OUT_BCD loads W with the new nibble merged in.
  - OUT_ERR loads err_acc OR the current error.
  - OUT_VALID is set.
  - seen and err_acc clear.
- Handshake:
  - A transfer occurs on an edge where OUT_VALID and OUT_READY are both high; OUT_VALID clears after it.
  - OUT_BCD and OUT_ERR stay stable while OUT_VALID is high, except when overwritten.
- Simultaneous transfer and completion: the new frame loads and OUT_VALID stays high. No OVERRUN.
- Completion while OUT_VALID is high and OUT_READY is low: the new frame overwrites the old one, OUT_VALID stays high, and OVERRUN pulses high for one cycle.

## Timing
- Reset values:
  - OUT_BCD=0, OUT_ERR=0, OUT_VALID=0, OVERRUN=0.
  - S=0, cnt=0, state=IDLE, seen=0, err_acc=0, W=0.
- Reset mid-frame discards the partial frame. Reset overrides a pending handshake.
- Latency from the input changing before edge e0 to the W update: STABLE_CYC+1 edges (e0 through e(STABLE_CYC)). With STABLE_CYC=1 this is 2 edges.
- OUT_VALID rises on the same edge that writes the final digit.
- A dwell shorter than STABLE_CYC registered samples is ignored entirely.
- A glitch returning to the same value restarts the count. If the digit was already HELD, it is re-accepted after settling.
- OVERRUN is never asserted in the same cycle as a completed handshake.

## Test plan
- Reset, then drive digits 0..3 with patterns 30,6D,79,33, dwell 6 cycles each (STABLE_CYC=4), OUT_READY=1 -> OUT_VALID pulses one cycle, OUT_BCD=16'h4321, OUT_ERR=0.
- Digit 2 driven with 7C (invalid), others 7E, 7E, 7E -> OUT_BCD=16'h0E00, OUT_ERR=1. Next clean frame gives OUT_ERR=0.
- Dwell of 3 cycles on digit 1 (STABLE_CYC=4), then full frame -> digit 1 is captured only from its later full dwell. No spurious frame. Input change to W update is measured as 5 edges.
- DIG_SEL=0011 with SEG=7F for 10 cycles -> no accept, state IDLE, seen unchanged.
- OUT_READY=0 across two completed frames (1234, then 5678) -> OVERRUN pulses once, OUT_BCD=16'h8765 (digit0=5 in the LSB nibble). Raising OUT_READY gives one transfer, then OUT_VALID=0.
- RST asserted after digits 0 and 1 are accepted, then a full frame 9,9,9,9 -> OUT_BCD=16'h9999. Only one frame is produced.
